dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/rv32i_types.sv | 22 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/dmem_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types for the data-memory arbiter.
//   dmem_req_t       : one latched memory request (address, byte masks, store data)
//   dmem_arb_state_t : arbiter FSM state encoding
package rv32i_types;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned MASK_W = 4;

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [XLEN-1:0]   wdata;
  } dmem_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } dmem_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches req starting at ptr and returns a one-hot grant.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this cycle
//   grant : one-hot grant, zero when no request is raised
module rr_arbiter #(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_IDX_W-1:0] ptr,
  output logic [NUM_REQ-1:0]   grant
);

  logic        found;
  int unsigned idx;

  // Walk offsets 0..NUM_REQ-1 from ptr; first raised request wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(ptr) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int unsigned j = 0; j < NUM_REQ; j++) begin
        if (!found && (idx == j) && req[j]) begin
          grant[j] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises load/store requesters onto one memory port.
//   clk, rst_n      : clock, async active-low reset
//   flush           : kills pending (IDLE) and in-flight (BUSY) loads
//   req_*           : requester side; req_ready is a combinational accept pulse
//   resp_valid/rdata: one-cycle response to the owning requester
//   dmem_*          : memory side, driven from latched registers outside IDLE
module dmem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned REQ_IDX_W = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][31:0]  req_addr,
  input  logic [NUM_REQ-1:0][3:0]   req_rmask,
  input  logic [NUM_REQ-1:0][3:0]   req_wmask,
  input  logic [NUM_REQ-1:0][31:0]  req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [31:0]               resp_rdata,
  output logic [31:0]               dmem_addr,
  output logic [3:0]                dmem_rmask,
  output logic [3:0]                dmem_wmask,
  output logic [31:0]               dmem_wdata,
  input  logic [31:0]               dmem_rdata,
  input  logic                      dmem_resp
);

  dmem_arb_state_t        state_q, state_d;
  logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [REQ_IDX_W-1:0]   owner_q, owner_d;
  dmem_req_t              lat_q, lat_d;
  logic [NUM_REQ-1:0]     resp_valid_q, resp_valid_d;
  logic [31:0]            rdata_q, rdata_d;

  logic [NUM_REQ-1:0]     eligible;
  logic [NUM_REQ-1:0]     grant;
  logic [REQ_IDX_W-1:0]   grant_idx;
  logic                   lat_is_nop;
  logic                   lat_is_load;
  int unsigned            ptr_nxt;

  // Loads are masked out while flushing; stores and no-ops stay eligible.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = req_valid[i] & ~(flush & (|req_rmask[i]) & ~(|req_wmask[i]));
    end
  end

  rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .REQ_IDX_W (REQ_IDX_W)
  ) u_rr (
    .req   (eligible),
    .ptr   (rr_ptr_q),
    .grant (grant)
  );

  // One-hot to index.
  always_comb begin
    grant_idx = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) grant_idx = REQ_IDX_W'(j);
    end
  end

  // rmask is cleared on latch when wmask is set, so a nonzero rmask means load.
  assign lat_is_nop  = (lat_q.rmask == 4'h0) && (lat_q.wmask == 4'h0);
  assign lat_is_load = (lat_q.rmask != 4'h0);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      lat_q        <= '0;
      resp_valid_q <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      owner_q      <= owner_d;
      lat_q        <= lat_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (|grant) state_d = BUSY;
      end
      BUSY: begin
        if (lat_is_nop || dmem_resp) state_d = IDLE;
        else if (flush && lat_is_load) state_d = DRAIN;
      end
      DRAIN: begin
        if (dmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values.
  always_comb begin
    req_ready    = '0;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    lat_d        = lat_q;
    resp_valid_d = '0;
    rdata_d      = rdata_q;
    ptr_nxt      = 32'(grant_idx) + 1;
    if (ptr_nxt >= NUM_REQ) ptr_nxt = 0;
    dmem_addr    = '0;
    dmem_rmask   = '0;
    dmem_wmask   = '0;
    dmem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        // Gated by rst_n so no accept pulse escapes while reset is held.
        req_ready = grant & {NUM_REQ{rst_n}};
        if (|grant) begin
          owner_d     = grant_idx;
          rr_ptr_d    = REQ_IDX_W'(ptr_nxt);
          lat_d.addr  = req_addr[grant_idx];
          lat_d.wmask = req_wmask[grant_idx];
          lat_d.rmask = (|req_wmask[grant_idx]) ? 4'h0 : req_rmask[grant_idx];
          lat_d.wdata = req_wdata[grant_idx];
        end
      end
      BUSY: begin
        if (lat_is_nop) begin
          resp_valid_d[owner_q] = 1'b1;
          rdata_d               = '0;
        end else begin
          dmem_addr  = lat_q.addr;
          dmem_rmask = lat_q.rmask;
          dmem_wmask = lat_q.wmask;
          dmem_wdata = lat_q.wdata;
          if (dmem_resp) begin
            rdata_d = dmem_rdata;
            if (!(flush && lat_is_load)) resp_valid_d[owner_q] = 1'b1;
          end
        end
      end
      DRAIN: begin
        dmem_addr  = lat_q.addr;
        dmem_rmask = lat_q.rmask;
        dmem_wmask = lat_q.wmask;
        dmem_wdata = lat_q.wdata;
      end
      default: ;
    endcase
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;

endmodule
